// File: rtl/rq_responder.sv
// Responder for the RQ request line: synchronises RQ, qualifies its width and
// answers a valid request with a start/data/parity/stop serial frame on tx.
module rq_responder #(
  parameter int DATA_W  = 16,
  parameter int BIT_DIV = 8,
  parameter int MIN_W   = 24,
  parameter int MAX_W   = 40
) (
  input  logic              clk80MHz,
  input  logic              rst,
  input  logic              RQ,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [7:0]        req_cnt
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 3);
  localparam int DIV_W     = $clog2(BIT_DIV);
  localparam int SHR_W     = DATA_W + 2;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W + 2);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [5:0]           MIN_W_C   = 6'(MIN_W);
  localparam logic [5:0]           MAX_W_C   = 6'(MAX_W);
  localparam logic [5:0]           WIDTH_SAT = 6'd63;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEAS    = 2'd1,
    S_SEND    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t               state_q, state_d;
  logic [5:0]           width_q, width_d;
  logic [SHR_W-1:0]     shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;

  logic rq_meta_q, rq_sync_q, rq_sync_dly_q;
  logic rise_s, width_ok_s, div_last_s;

  // Synchroniser and edge-detect delay; intentionally free of reset.
  always_ff @(posedge clk80MHz) begin
    rq_meta_q     <= RQ;
    rq_sync_q     <= rq_meta_q;
    rq_sync_dly_q <= rq_sync_q;
  end

  assign rise_s     = rq_sync_q & ~rq_sync_dly_q;
  assign width_ok_s = (width_q >= MIN_W_C) && (width_q <= MAX_W_C);
  assign div_last_s = (div_q == DIV_LAST);

  // State and datapath registers.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      width_q   <= 6'd0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rise_s) state_d = S_MEAS;
        else        state_d = S_IDLE;
      end
      S_MEAS: begin
        if (rq_sync_q) begin
          if (width_q == MAX_W_C) state_d = S_RECOVER;
          else                    state_d = S_MEAS;
        end else if (width_ok_s) begin
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (div_last_s && (bit_cnt_q == LAST_BIT)) state_d = S_IDLE;
        else                                       state_d = S_SEND;
      end
      S_RECOVER: begin
        if (!rq_sync_q) state_d = S_IDLE;
        else            state_d = S_RECOVER;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; the shift register holds {stop, parity, data}.
  always_comb begin
    width_d   = width_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rise_s) width_d = 6'd1;
        else        width_d = width_q;
      end
      S_MEAS: begin
        if (rq_sync_q) begin
          if (width_q == MAX_W_C)         err_d   = 1'b1;
          else if (width_q != WIDTH_SAT)  width_d = width_q + 6'd1;
          else                            width_d = width_q;
        end else if (width_ok_s) begin
          ack_d     = 1'b1;
          shreg_d   = {1'b1, parity_f(data), data};
          cnt_d     = cnt_q + 8'd1;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          div_d     = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      S_SEND: begin
        if (div_last_s) begin
          div_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            busy_d = 1'b0;
            tx_d   = 1'b1;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = {1'b1, shreg_q[SHR_W-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_RECOVER: begin
        width_d = width_q;
      end
      default: begin
        width_d = 6'd0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign req_cnt = cnt_q;

endmodule

// File: tb/tb_rq_responder.sv
// Scoreboard bench for rq_responder: stimulus pushes expected ack/err events and
// frames into queues; monitors on the falling clock edge pop and compare.
`timescale 1ns/100ps
module tb_rq_responder;

  logic        clk80MHz = 1'b0;
  logic        rst      = 1'b0;
  logic        RQ       = 1'b0;
  logic [15:0] data     = 16'h0000;
  logic        tx, busy, ack, err;
  logic [7:0]  req_cnt;

  rq_responder dut (
    .clk80MHz(clk80MHz), .rst(rst), .RQ(RQ), .data(data),
    .tx(tx), .busy(busy), .ack(ack), .err(err), .req_cnt(req_cnt)
  );

  always #6.25 clk80MHz = ~clk80MHz;

  typedef struct { bit is_ack; logic [7:0] cnt; } ev_t;
  ev_t         ev_q[$];
  logic [15:0] frame_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  int          frames_done = 0;
  logic        err_rq_level = 1'b0;
  logic [18:0] last_frame = 19'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event monitor: every ack/err must match the next expected event.
  always @(negedge clk80MHz) begin
    ev_t e;
    if (rst && (ack || err)) begin
      if (ack && err) check("ack_err_exclusive", {30'd0, ack, err}, 32'd0);
      if (ev_q.size() == 0) begin
        check("unexpected_event", {30'd0, ack, err}, 32'd0);
      end else begin
        e = ev_q.pop_front();
        check("event_kind_ack", {31'd0, ack}, {31'd0, e.is_ack});
        if (ack) check("req_cnt_on_ack", {24'd0, req_cnt}, {24'd0, e.cnt});
        if (err) err_rq_level = RQ;
      end
    end
  end

  // Frame monitor: samples tx mid-bit and measures busy length.
  logic        fr_active = 1'b0;
  logic        fr_unexp  = 1'b0;
  int          fr_cyc    = 0;
  logic [18:0] exp_frame = 19'h0;
  always @(negedge clk80MHz) begin
    logic [15:0] d;
    if (!rst) begin
      fr_active = 1'b0;
    end else begin
      if (busy && !fr_active) begin
        fr_active = 1'b1;
        fr_cyc    = 0;
        if (frame_q.size() == 0) begin
          fr_unexp = 1'b1;
          check("unexpected_frame", {31'd0, busy}, 32'd0);
        end else begin
          fr_unexp  = 1'b0;
          d         = frame_q.pop_front();
          exp_frame = {1'b1, ^d, d, 1'b0};
        end
      end
      if (fr_active) begin
        if (busy) begin
          if ((fr_cyc % 8) == 4 && fr_cyc < 152) begin
            last_frame[fr_cyc / 8] = tx;
            if (!fr_unexp) check("tx_bit", {31'd0, tx}, {31'd0, exp_frame[fr_cyc / 8]});
          end
          fr_cyc++;
        end else begin
          if (!fr_unexp) check("busy_length", fr_cyc, 32'd152);
          fr_active = 1'b0;
          frames_done++;
        end
      end
    end
  end

  task automatic pulse(input int n);
    @(posedge clk80MHz); #1 RQ = 1'b1;
    repeat (n) @(posedge clk80MHz);
    #1 RQ = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    repeat (6) @(posedge clk80MHz);
    while (busy && k < 400) begin
      @(posedge clk80MHz);
      k++;
    end
    check("busy_timeout", {31'd0, k < 400}, 32'd1);
    repeat (3) @(posedge clk80MHz);
    #1;
  endtask

  task automatic expect_ack(input logic [15:0] d);
    ev_t e;
    exp_cnt   = (exp_cnt + 1) % 256;
    e.is_ack  = 1'b1;
    e.cnt     = 8'(exp_cnt);
    ev_q.push_back(e);
    frame_q.push_back(d);
  endtask

  task automatic request(input int n, input logic [15:0] d, input bit accept);
    ev_t e;
    data = d;
    if (accept) begin
      expect_ack(d);
    end else begin
      e.is_ack = 1'b0;
      e.cnt    = 8'd0;
      ev_q.push_back(e);
    end
    pulse(n);
    wait_idle();
  endtask

  task automatic reset_dut();
    @(posedge clk80MHz); #2 rst = 1'b0;
    repeat (3) @(posedge clk80MHz);
    #2 rst = 1'b1;
    exp_cnt = 0;
    repeat (2) @(posedge clk80MHz);
    #1;
  endtask

  initial begin
    #(1_200_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int fd;
    repeat (3) @(posedge clk80MHz);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_req_cnt", {24'd0, req_cnt}, 32'd0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk80MHz);

    // Valid request with hand-computed frame.
    request(32, 16'hA5C3, 1'b1);
    check("frame_A5C3", {13'd0, last_frame}, {13'd0, 19'h54B86});
    check("req_cnt_first", {24'd0, req_cnt}, 32'd1);

    // Short pulse rejected.
    request(10, 16'h1234, 1'b0);
    check("short_req_cnt", {24'd0, req_cnt}, 32'd1);
    check("short_tx_idle", {31'd0, tx}, 32'd1);

    // Window boundaries.
    request(24, 16'h0001, 1'b1);
    request(23, 16'h0002, 1'b0);
    request(40, 16'hFFFF, 1'b1);
    request(41, 16'h8000, 1'b0);
    check("boundary_req_cnt", {24'd0, req_cnt}, 32'd3);

    // Long pulse: err while RQ still high, then a normal request.
    err_rq_level = 1'b0;
    request(100, 16'h5555, 1'b0);
    check("long_err_while_high", {31'd0, err_rq_level}, 32'd1);
    request(32, 16'h7E81, 1'b1);
    check("after_long_req_cnt", {24'd0, req_cnt}, 32'd4);

    // Request during SEND is ignored.
    data = 16'hC0DE;
    expect_ack(16'hC0DE);
    pulse(32);
    repeat (20) @(posedge clk80MHz);
    #1 check("busy_during_send", {31'd0, busy}, 32'd1);
    data = 16'hFFFF;
    pulse(32);
    wait_idle();
    check("ignored_req_cnt", {24'd0, req_cnt}, 32'd5);
    check("frame_C0DE", {13'd0, last_frame}, {13'd0, 1'b1, ^16'hC0DE, 16'hC0DE, 1'b0});
    request(32, 16'h0F0F, 1'b1);
    check("after_send_req_cnt", {24'd0, req_cnt}, 32'd6);

    // Reset mid-frame.
    data = 16'h3C3C;
    expect_ack(16'h3C3C);
    pulse(32);
    k = 0;
    while (!busy && k < 20) begin
      @(posedge clk80MHz);
      k++;
    end
    check("busy_start_timeout", {31'd0, k < 20}, 32'd1);
    repeat (50) @(posedge clk80MHz);
    #2 rst = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_req_cnt", {24'd0, req_cnt}, 32'd0);
    repeat (3) @(posedge clk80MHz);
    #2 rst = 1'b1;
    exp_cnt = 0;
    repeat (3) @(posedge clk80MHz);
    fd = frames_done;
    request(32, 16'h9ABC, 1'b1);
    check("post_reset_frame", frames_done - fd, 32'd1);
    check("post_reset_req_cnt", {24'd0, req_cnt}, 32'd1);

    // Counter wrap.
    reset_dut();
    for (int i = 1; i <= 257; i++) begin
      request(24 + (i % 17), 16'(i * 40503), 1'b1);
      if (i == 255) check("wrap_255", {24'd0, req_cnt}, 32'd255);
      if (i == 256) check("wrap_256", {24'd0, req_cnt}, 32'd0);
      if (i == 257) check("wrap_257", {24'd0, req_cnt}, 32'd1);
    end

    check("events_drained", ev_q.size(), 32'd0);
    check("frames_drained", frame_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
